// File: rtl/i2c_pkg.sv
// Constants shared by the I2C target and master: FSM encoding, R/W and ACK levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_SUBADDR   = 3'd3,
    ST_WRITE     = 3'd4,
    ST_READ      = 3'd5,
    ST_WAIT_STOP = 3'd6
  } i2c_state_e;

  localparam logic       RW_WRITE           = 1'b0;
  localparam logic       RW_READ            = 1'b1;
  localparam logic       ACK                = 1'b0;
  localparam logic       NACK               = 1'b1;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h5C;

endpackage

// File: rtl/i2c_line_filter.sv
// Pin conditioning: 2-flop synchronizer, saturating glitch filter, registered edge pulses.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Level flips only after FILTER_LEN consecutive samples disagree with it; idle bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing an 8-bit pointer / 8-bit data register file with auto-increment bursts.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .pin(scl_i), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .pin(sda_i), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e state;
  logic [3:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] tx;
  logic       rw;
  logic       rd_pend;

  logic       start_c, stop_c, match_c;
  logic [7:0] rx_byte_c;

  assign start_c   = sda_fall & scl;
  assign stop_c    = sda_rise & scl;
  assign rx_byte_c = {shift, sda};
  assign match_c   = (rx_byte_c[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'd0);

  // bit_cnt 0..7 counts data bits; 8 marks the ACK clock; 9 means master ACKed a read byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      rw        <= RW_WRITE;
      rd_pend   <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      rd_pend <= reg_re;
      if (rd_pend) tx <= reg_rdata;

      if (stop_c) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else if (start_c) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_SUBADDR, ST_WRITE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[5:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == ST_ADDR) begin
                  if (match_c) begin
                    busy  <= 1'b1;
                    rw    <= rx_byte_c[0];
                    state <= ST_ADDR_ACK;
                  end else begin
                    state <= ST_WAIT_STOP;
                  end
                end else if (state == ST_SUBADDR) begin
                  reg_addr <= rx_byte_c;
                end else begin
                  reg_wdata <= rx_byte_c;
                  reg_we    <= 1'b1;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (state == ST_SUBADDR) state <= ST_WRITE;
                else                     reg_addr <= reg_addr + 8'd1;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_rise && sda_oe && rw == RW_READ) begin
              reg_re <= 1'b1;
            end else if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (rw == RW_READ) begin
                  state  <= ST_READ;
                  sda_oe <= ~tx[7];
                end else begin
                  state  <= ST_SUBADDR;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          ST_READ: begin
            if (scl_rise) begin
              if (bit_cnt < 4'd8) begin
                bit_cnt <= bit_cnt + 4'd1;
              end else if (bit_cnt == 4'd8) begin
                reg_addr <= reg_addr + 8'd1;
                if (sda == ACK) begin
                  reg_re  <= 1'b1;
                  bit_cnt <= 4'd9;
                end else begin
                  state   <= ST_WAIT_STOP;
                  bit_cnt <= '0;
                end
              end
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
              end else if (bit_cnt == 4'd9) begin
                sda_oe  <= ~tx[7];
                bit_cnt <= '0;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[6:0], 1'b0};
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register-file model, write/read scoreboards.
`timescale 1ns/1ps
module tb_i2c_slave_regs;
  import i2c_pkg::*;

  localparam int unsigned Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_we, reg_re, busy;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  int n_vec = 0, n_miss = 0;
  int extra = 0, oe_cnt = 0, busy_cnt = 0;
  logic [15:0] we_q [$];
  logic [7:0]  re_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: strobes are compared against the queued expectations as they appear.
  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (reg_we) begin
      if (we_q.size() > 0) chk("reg_we", 32'({reg_addr, reg_wdata}), 32'(we_q.pop_front()));
      else extra++;
    end
    if (reg_re) begin
      if (re_q.size() > 0) chk("reg_re_addr", 32'(reg_addr), 32'(re_q.pop_front()));
      else extra++;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(2 * Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); b = sda_bus; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         oe0, busy0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;

    tick(4);
    chk("rst_sda_oe", 32'(sda_oe), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_reg_addr", 32'(reg_addr), 32'(0));
    chk("rst_reg_wdata", 32'(reg_wdata), 32'(0));
    chk("rst_reg_we", 32'(reg_we), 32'(0));
    chk("rst_reg_re", 32'(reg_re), 32'(0));
    rst = 1'b0;
    tick(10);

    // single write
    we_q.push_back(16'h10A5);
    i2c_start();
    put_byte(8'hB8, a); chk("t1_addr_ack", 32'(a), 32'(ACK));
    chk("t1_busy", 32'(busy), 32'(1));
    put_byte(8'h10, a); chk("t1_sub_ack", 32'(a), 32'(ACK));
    put_byte(8'hA5, a); chk("t1_data_ack", 32'(a), 32'(ACK));
    i2c_stop();
    chk("t1_busy_end", 32'(busy), 32'(0));
    chk("t1_ptr", 32'(reg_addr), 32'(8'h11));

    // burst write wrapping the pointer
    we_q.push_back(16'hFF11);
    we_q.push_back(16'h0022);
    i2c_start();
    put_byte(8'hB8, a); chk("t2_addr_ack", 32'(a), 32'(ACK));
    put_byte(8'hFF, a); chk("t2_sub_ack", 32'(a), 32'(ACK));
    put_byte(8'h11, a); chk("t2_d0_ack", 32'(a), 32'(ACK));
    put_byte(8'h22, a); chk("t2_d1_ack", 32'(a), 32'(ACK));
    i2c_stop();
    chk("t2_ptr", 32'(reg_addr), 32'(8'h01));
    chk("t2_we_left", 32'(we_q.size()), 32'(0));

    // random read with repeated START
    re_q.push_back(8'h20);
    re_q.push_back(8'h21);
    i2c_start();
    put_byte(8'hB8, a); chk("t3_waddr_ack", 32'(a), 32'(ACK));
    put_byte(8'h20, a); chk("t3_sub_ack", 32'(a), 32'(ACK));
    i2c_rstart();
    put_byte(8'hB9, a); chk("t3_raddr_ack", 32'(a), 32'(ACK));
    get_byte(d, ACK);  chk("t3_rd0", 32'(d), 32'(8'h3C));
    get_byte(d, NACK); chk("t3_rd1", 32'(d), 32'(8'hC3));
    i2c_stop();
    chk("t3_ptr", 32'(reg_addr), 32'(8'h22));
    chk("t3_busy_end", 32'(busy), 32'(0));
    chk("t3_re_left", 32'(re_q.size()), 32'(0));

    // address mismatch
    oe0 = oe_cnt;
    busy0 = busy_cnt;
    i2c_start();
    put_byte(8'hA0, a); chk("t4_addr_nack", 32'(a), 32'(NACK));
    put_byte(8'h10, a); chk("t4_sub_nack", 32'(a), 32'(NACK));
    put_byte(8'h55, a);
    i2c_stop();
    chk("t4_oe_never", 32'(oe_cnt - oe0), 32'(0));
    chk("t4_busy_never", 32'(busy_cnt - busy0), 32'(0));
    chk("t4_ptr", 32'(reg_addr), 32'(8'h22));

    // 1-clk SCL glitch before the sub-address must not shift a bit
    we_q.push_back(16'h1077);
    i2c_start();
    put_byte(8'hB8, a); chk("t5_addr_ack", 32'(a), 32'(ACK));
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(Q);
    put_byte(8'h10, a); chk("t5_sub_ack", 32'(a), 32'(ACK));
    put_byte(8'h77, a); chk("t5_data_ack", 32'(a), 32'(ACK));
    i2c_stop();
    chk("t5_we_left", 32'(we_q.size()), 32'(0));
    chk("t5_ptr", 32'(reg_addr), 32'(8'h11));

    // STOP after 4 data bits: partial byte dropped
    i2c_start();
    put_byte(8'hB8, a);
    put_byte(8'h30, a); chk("t6_sub_ack", 32'(a), 32'(ACK));
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    chk("t6_ptr", 32'(reg_addr), 32'(8'h30));
    chk("t6_busy_end", 32'(busy), 32'(0));

    // reset while the target drives SDA low in a read
    re_q.push_back(8'h30);
    i2c_start();
    put_byte(8'hB9, a); chk("t7_addr_ack", 32'(a), 32'(ACK));
    chk("t7_driving", 32'(sda_oe), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_sda_oe", 32'(sda_oe), 32'(0));
    chk("t7_rst_busy", 32'(busy), 32'(0));
    chk("t7_rst_ptr", 32'(reg_addr), 32'(0));
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(20);

    chk("we_left", 32'(we_q.size()), 32'(0));
    chk("re_left", 32'(re_q.size()), 32'(0));
    chk("unexpected_strobes", 32'(extra), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (slave) endpoint: the responder to our I2C master controller.
- Exposes an 8-bit-addressed, 8-bit-data register file to an external I2C host. Intended use is bench loop-back against the master and board-level config access.
- Runs entirely in the `clk` domain. SCL and SDA are oversampled; the block never drives SCL (no clock stretching).
- Protocol: 7-bit address, 8-bit sub-address pointer, auto-incrementing burst writes and reads, repeated START supported.

Parameters:
- SLAVE_ADDR, 7'h5C, 7-bit target address matched against the first byte after START/Sr.
- FILTER_LEN, 3, consecutive equal samples needed before a filtered SCL/SDA level changes (glitch rejection).

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- scl_i  in  1  raw SCL pin level (asynchronous)
- sda_i  in  1  raw SDA pin level (asynchronous)
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad is open-drain, top level ties output data to 0)
- reg_addr  out  8  current register pointer
- reg_wdata  out  8  received data byte
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read request; reg_rdata sampled exactly 1 clk later
- reg_rdata  in  8  read data from the register file
- busy  out  1  high from a START addressed to us until STOP

Behaviour:
- Reset: sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state=IDLE. Reset is asynchronous and may arrive mid-transaction; the block releases SDA immediately.
- Input conditioning: 2-flop synchronizer per pin, then a FILTER_LEN saturating filter. Edge detects (scl_rise, scl_fall) come from the filtered levels.
- START/Sr: filtered SDA falls while filtered SCL=1.
  - From any state: goto ADDR, bit counter=0, sda_oe=0.
- STOP: filtered SDA rises while SCL=1.
  - From any state: goto IDLE, busy=0, sda_oe=0.
  - A partial byte is discarded and produces no strobe.
- Bit timing:
  - SDA is sampled on scl_rise, MSB first.
  - sda_oe changes only on the cycle after scl_fall, so the slave's data-hold time is at least the filter delay.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits.
    - {SLAVE_ADDR,R/W} match: busy=1, goto ADDR_ACK.
    - Mismatch: goto WAIT_STOP, no ACK.
  - ADDR_ACK: drive ACK (sda_oe=1) for the 9th clock, release on the following scl_fall.
    - W: goto SUBADDR.
    - R: pulse reg_re at the ACK scl_rise, latch reg_rdata into the TX shifter 1 clk later, goto READ.
  - SUBADDR: shift 8 bits, load reg_addr, ACK, goto WRITE.
  - WRITE: shift 8 bits; on the 8th scl_rise set reg_wdata and pulse reg_we (reg_addr = pointer). ACK; on ACK release, reg_addr+1 (8-bit wrap 0xFF→0x00). Stay in WRITE.
  - READ:
    - Drive the TX shifter MSB-first: sda_oe = ~bit.
    - Release SDA for the 9th clock and sample the master ACK on scl_rise.
    - ACK (0): reg_addr+1, pulse reg_re, reload shifter, stay in READ.
    - NACK (1): goto WAIT_STOP, reg_addr+1.
  - WAIT_STOP: SDA released. Only START or STOP is recognised.
- Read-after-write pointer: a write transaction carrying only the sub-address sets reg_addr; a following Sr+read starts at that address.
- Simultaneous events: START/STOP detection has priority over any scl edge processed in the same clk.
- The block never ACKs a general-call address (0x00).

Decomposition:
- Shared package i2c_pkg: state enum encoding, RW_WRITE/RW_READ, ACK/NACK levels, default SLAVE_ADDR. Place these in the package so the master can move to the same constants.
- One sub-module: i2c_line_filter (synchronizer + glitch filter + rise/fall outputs), instantiated for SCL and SDA. It is reusable by the master.

Test Plan:
- Write: START, 0xB8, 0x10, 0xA5, STOP → three ACKs; one reg_we with reg_addr=0x10, reg_wdata=0xA5; busy returns to 0 after STOP.
- Burst write with wrap: START, 0xB8, 0xFF, 0x11, 0x22, STOP → reg_we at 0xFF/0x11, then at 0x00/0x22.
- Random read with Sr: START, 0xB8, 0x20, Sr, 0xB9, master ACK, master NACK, STOP, register model 0x20=0x3C, 0x21=0xC3 → SDA bytes 0x3C then 0xC3; two reg_re pulses; ends in IDLE.
- Address mismatch: START, 0xA0, 0x10, 0x55, STOP → sda_oe never 1, no reg_we/reg_re, busy stays 0.
- Glitch/abort: 1-clk pulse on scl_i is ignored (no bit shifted); STOP after 4 data bits → no reg_we, IDLE; assert rst mid-READ with SDA low → sda_oe=0 in the same cycle.
